// File: rtl/prog_loader_pkg.sv
// prog_loader shared types and constants.
// Boot-time instruction memory writer.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    FLUSH,
    DONE,
    ERR
  } state_t;

  localparam int RAM_WIDTH_DEF  = 32;
  localparam int BYTES_PER_WORD = RAM_WIDTH_DEF / 8;
  localparam int BYTE_CNT_BITS  = $clog2(BYTES_PER_WORD);

  // Byte counter width for a given word width, never narrower than 1.
  function automatic int cnt_bits(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// word_out is the completed word while word_done is high.
module byte_packer
  import prog_loader_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_en,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_done
);

  localparam int BPW = WIDTH / 8;
  localparam int CB  = cnt_bits(WIDTH);
  localparam logic [CB-1:0] LAST = CB'(BPW - 1);

  logic [CB-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (byte_en) begin
      r_word[8*r_cnt +: 8] <= byte_in;
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Final byte is merged combinationally so the word is usable on its handshake edge.
  always_comb begin
    word_out = r_word;
    word_out[WIDTH-1 -: 8] = byte_in;
  end

  assign word_done = byte_en && (r_cnt == LAST);

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed byte image into program bram,
// holding the processor in reset until the image is complete.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  output logic                     cpu_reset,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IW = RAM_ADDR_BITS + 1;
  localparam logic [RAM_WIDTH-1:0] MAX_N = RAM_WIDTH'(2 ** RAM_ADDR_BITS);

  state_t r_state;
  state_t w_next;

  logic                     w_hs;
  logic                     w_clear;
  logic                     w_word_done;
  logic                     w_hdr_ok;
  logic                     w_last;
  logic [RAM_WIDTH-1:0]     w_word;
  logic [IW-1:0]            r_n;
  logic [IW-1:0]            r_idx;
  logic                     r_we;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [RAM_WIDTH-1:0]     r_wdata;

  assign w_hs     = in_valid && in_ready;
  assign w_clear  = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_hdr_ok = (w_word != '0) && (w_word <= MAX_N);
  assign w_last   = (r_idx + 1'b1) == r_n;

  byte_packer #(
    .WIDTH(RAM_WIDTH)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .byte_en  (w_hs),
    .byte_in  (in_data),
    .word_out (w_word),
    .word_done(w_word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_reset = 1'b1;
    unique case (r_state)
      IDLE: if (start) w_next = HDR;
      HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_word_done) w_next = w_hdr_ok ? DATA : ERR;
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_word_done && w_last) w_next = FLUSH;
      end
      FLUSH: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) w_next = HDR;
      end
      ERR: begin
        err = 1'b1;
        if (start) w_next = HDR;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n     <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_state == HDR && w_word_done && w_hdr_ok) begin
        r_n   <= w_word[IW-1:0];
        r_idx <= '0;
      end
      if (r_state == DATA && w_word_done) begin
        r_we    <= 1'b1;
        r_addr  <= r_idx[RAM_ADDR_BITS-1:0];
        r_wdata <= w_word;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Writes are captured on the falling edge and compared to hand-computed values.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [8:0]  wa[$];
  logic [31:0] wd[$];

  prog_loader #(
    .RAM_WIDTH    (32),
    .RAM_ADDR_BITS(9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    logic acc;
    t = 0;
    acc = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    while (!acc && t < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total_cnt++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err} !==
        {1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state: got rdy=%b we=%b a=%h d=%h cr=%b b=%b dn=%b e=%b",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err);
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    wa.delete();
    wd.delete();
    pulse_start();
    @(negedge clk);
    total_cnt++;
    if ({busy, in_ready, cpu_reset, done} !== 4'b1110)
      $display("FAIL hdr_state: got %b required 1110", {busy, in_ready, cpu_reset, done});
    else pass_cnt++;
    @(posedge clk);
    #1;
    send_word(32'd3);
    send_word(32'h2080_1000);
    send_word(32'h1108_2000);
    send_word(32'h2000_0004);
    @(negedge clk);
    total_cnt++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'd2, 32'h2000_0004})
      $display("FAIL flush_write: got we=%b a=%h d=%h required 1/002/20000004",
               mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({busy, in_ready, cpu_reset, done} !== 4'b1010)
      $display("FAIL flush_state: got %b required 1010", {busy, in_ready, cpu_reset, done});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, cpu_reset, mem_we, err, mem_addr, mem_wdata} !==
        {5'b01000, 9'd2, 32'h2000_0004})
      $display("FAIL done_state: got b=%b dn=%b cr=%b we=%b e=%b a=%h d=%h",
               busy, done, cpu_reset, mem_we, err, mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if ({wa.size(), wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !==
        {32'd3, 9'd0, 32'h2080_1000, 9'd1, 32'h1108_2000, 9'd2, 32'h2000_0004})
      $display("FAIL basic_writes: got n=%0d %h:%h %h:%h %h:%h", wa.size(),
               wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
    else pass_cnt++;
  endtask

  task automatic test_hdr_err();
    int bad;
    logic [31:0] exp_d;
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd0);
    @(negedge clk);
    total_cnt++;
    if ({err, cpu_reset, busy, done, in_ready, mem_we} !== 6'b110000)
      $display("FAIL hdr_zero: got %b required 110000",
               {err, cpu_reset, busy, done, in_ready, mem_we});
    else pass_cnt++;
    pulse_start();
    send_word(32'd513);
    @(negedge clk);
    total_cnt++;
    if ({err, cpu_reset, busy, done} !== 4'b1100)
      $display("FAIL hdr_513: got %b required 1100", {err, cpu_reset, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (wa.size() !== 0)
      $display("FAIL err_no_write: got %0d writes required 0", wa.size());
    else pass_cnt++;
    pulse_start();
    send_word(32'd512);
    for (int i = 0; i < 512; i++) send_word(32'h1000_0000 + i * 32'h0001_0003);
    @(negedge clk);
    total_cnt++;
    if ({mem_we, mem_addr} !== {1'b1, 9'd511})
      $display("FAIL full_last_addr: got we=%b a=%0d required 1/511", mem_we, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, err, cpu_reset} !== 3'b100)
      $display("FAIL full_done: got %b required 100", {done, err, cpu_reset});
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      exp_d = 32'h1000_0000 + i * 32'h0001_0003;
      if (wa[i] !== 9'(i) || wd[i] !== exp_d) bad++;
    end
    total_cnt++;
    if (wa.size() !== 512 || bad != 0)
      $display("FAIL full_writes: got n=%0d bad=%0d required 512/0", wa.size(), bad);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    int rdy_bad;
    int n;
    logic [31:0] w[3];
    w[0] = 32'd2;
    w[1] = 32'hA1B2_C3D4;
    w[2] = 32'h0102_0304;
    rdy_bad = 0;
    wa.delete();
    wd.delete();
    pulse_start();
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 4; k++) begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          in_valid = 1'b0;
          @(negedge clk);
          if (in_ready !== 1'b1) rdy_bad++;
          @(posedge clk);
          #1;
        end
        send_byte(w[j][8*k +: 8]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (rdy_bad != 0)
      $display("FAIL gap_ready: got %0d idle cycles with in_ready low required 0", rdy_bad);
    else pass_cnt++;
    total_cnt++;
    if ({wa.size(), wa[0], wd[0], wa[1], wd[1], done} !==
        {32'd2, 9'd0, 32'hA1B2_C3D4, 9'd1, 32'h0102_0304, 1'b1})
      $display("FAIL gap_writes: got n=%0d %h:%h %h:%h done=%b", wa.size(),
               wa[0], wd[0], wa[1], wd[1], done);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    total_cnt++;
    if ({wa.size(), wa[0], wd[0]} !== {32'd1, 9'd0, 32'h1122_3344})
      $display("FAIL mid_first_word: got n=%0d %h:%h", wa.size(), wa[0], wd[0]);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, cpu_reset, mem_we, in_ready, done, err, mem_addr, mem_wdata} !==
        {6'b010000, 9'd0, 32'd0})
      $display("FAIL mid_reset: got b=%b cr=%b we=%b rdy=%b dn=%b e=%b a=%h d=%h",
               busy, cpu_reset, mem_we, in_ready, done, err, mem_addr, mem_wdata);
    else pass_cnt++;
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({wa.size(), wa[0], wd[0], done} !== {32'd1, 9'd0, 32'hCAFE_F00D, 1'b1})
      $display("FAIL mid_reload: got n=%0d %h:%h done=%b", wa.size(), wa[0], wd[0], done);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic [31:0] w;
    wa.delete();
    wd.delete();
    pulse_start();
    send_word(32'd2);
    w = 32'h0BAD_F00D;
    start = 1'b1;
    send_byte(w[7:0]);
    start = 1'b0;
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
    w = 32'h7654_3210;
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    start = 1'b1;
    send_byte(w[23:16]);
    start = 1'b0;
    send_byte(w[31:24]);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({wa.size(), wa[0], wd[0], wa[1], wd[1], done, cpu_reset} !==
        {32'd2, 9'd0, 32'h0BAD_F00D, 9'd1, 32'h7654_3210, 2'b10})
      $display("FAIL start_ignored: got n=%0d %h:%h %h:%h dn=%b cr=%b", wa.size(),
               wa[0], wd[0], wa[1], wd[1], done, cpu_reset);
    else pass_cnt++;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (cpu_reset !== 1'b0)
      $display("FAIL restart_pre: got cpu_reset=%b required 0", cpu_reset);
    else pass_cnt++;
    @(posedge clk);
    #1;
    start = 1'b0;
    total_cnt++;
    if ({cpu_reset, busy, done} !== 3'b110)
      $display("FAIL restart_edge: got %b required 110", {cpu_reset, busy, done});
    else pass_cnt++;
    wa.delete();
    wd.delete();
    send_word(32'd1);
    send_word(32'h55AA_33CC);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({wa.size(), wa[0], wd[0], done} !== {32'd1, 9'd0, 32'h55AA_33CC, 1'b1})
      $display("FAIL reload_overwrite: got n=%0d %h:%h done=%b", wa.size(),
               wa[0], wd[0], done);
    else pass_cnt++;
  endtask

  task automatic test_idle_valid();
    int bad;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wa.delete();
    wd.delete();
    bad = 0;
    in_valid = 1'b1;
    in_data = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL idle_valid: got %0d cycles with in_ready/busy high required 0", bad);
    else pass_cnt++;
    pulse_start();
    send_word(32'd1);
    send_word(32'h4433_2211);
    @(negedge clk);
    @(negedge clk);
    bad = 0;
    in_valid = 1'b1;
    in_data = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || done !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (bad != 0)
      $display("FAIL done_valid: got %0d bad cycles required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if ({wa.size(), wa[0], wd[0]} !== {32'd1, 9'd0, 32'h4433_2211})
      $display("FAIL first_byte_lsb: got n=%0d %h:%h required 1 000:44332211",
               wa.size(), wa[0], wd[0]);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_basic();
    test_hdr_err();
    test_gaps();
    test_reset_mid();
    test_start_ignored();
    test_idle_valid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
